// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM encoding,
// default data-segment base and the fill word returned on a timed-out load.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;
  localparam logic [31:0] TIMEOUT_FILL      = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: runs req/ack loads/stores and freezes the pipe until done.
// Optional MEM_STAGE_TIMEOUT_EN adds an ack-wait timeout with a sticky mem_err flag.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] DATA_BASE = DATA_BASE_DEFAULT,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic              MEM_R_en_in,
  input  logic              MEM_W_en_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       ST_val_in,
  input  logic [4:0]        Dest_in,
  output logic              WB_en,
  output logic              MEM_R_en,
  output logic [31:0]       ALU_result,
  output logic [31:0]       Mem_read_value,
  output logic [4:0]        Dest,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err
);

  state_t      state_reg;
  logic [31:0] rdata_reg;
  logic [31:0] byte_off;
  logic        mem_op;
  logic        timeout_hit;

  assign mem_op   = MEM_R_en_in | MEM_W_en_in;
  assign byte_off = ALU_result_in - DATA_BASE;

  assign WB_en          = WB_en_in;
  assign MEM_R_en       = MEM_R_en_in;
  assign ALU_result     = ALU_result_in;
  assign Dest           = Dest_in;
  assign Mem_read_value = rdata_reg;

  // Freeze rises combinationally in the detect cycle so upstream never advances past the op.
  assign freeze = rst & (((state_reg == ST_IDLE) & mem_op) | (state_reg == ST_ACCESS));

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             err_reg;

  assign timeout_hit = (state_reg == ST_ACCESS) && !mem_ack &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign mem_err     = err_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == ST_ACCESS) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                        wait_cnt_reg <= '0;
      if (timeout_hit) err_reg <= 1'b1;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = |TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mem_op) begin
            state_reg <= ST_ACCESS;
            mem_req   <= 1'b1;
            mem_we    <= MEM_W_en_in;
            mem_addr  <= ADDR_W'(byte_off >> 2);
            mem_wdata <= ST_val_in;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state_reg <= ST_DONE;
            mem_req   <= 1'b0;
            if (!mem_we) rdata_reg <= mem_rdata;
          end else if (timeout_hit) begin
            state_reg <= ST_DONE;
            mem_req   <= 1'b0;
            if (!mem_we) rdata_reg <= TIMEOUT_FILL;
          end
        end
        // The instruction is still on the inputs here; skip it so it is not issued twice.
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
